// File: rtl/setbit_enum_pkg.sv
// Shared definitions for the set-bit enumerator: default width and FSM state encoding.
package setbit_enum_pkg;

    localparam int unsigned DefaultWidth = 64;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

endpackage

// File: rtl/setbit_enum_if.sv
// Vector-in / index-stream-out handshake bundle for setbit_enum.
interface setbit_enum_if #(
    parameter int unsigned WIDTH = setbit_enum_pkg::DefaultWidth
);

    localparam int unsigned IDXW = $clog2(WIDTH);

    logic              setbit_valid_i;
    logic              setbit_ready_o;
    logic [WIDTH-1:0]  setbit_vec_i;
    logic              setbit_valid_o;
    logic              setbit_ready_i;
    logic [IDXW-1:0]   setbit_idx_o;
    logic              setbit_last_o;
    logic              setbit_any_o;

    // Enumerator side.
    modport slave (
        input  setbit_valid_i,
        input  setbit_vec_i,
        input  setbit_ready_i,
        output setbit_ready_o,
        output setbit_valid_o,
        output setbit_idx_o,
        output setbit_last_o,
        output setbit_any_o
    );

    // Producer/consumer side.
    modport master (
        output setbit_valid_i,
        output setbit_vec_i,
        output setbit_ready_i,
        input  setbit_ready_o,
        input  setbit_valid_o,
        input  setbit_idx_o,
        input  setbit_last_o,
        input  setbit_any_o
    );

endinterface

// File: rtl/lsb_penc.sv
// Lowest-set-bit priority encoder; also flags when at most one bit is set.
module lsb_penc #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0]         rem_i,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     last_o
);

    localparam int unsigned IDXW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (rem_i[i] && !found) begin
                idx_o = IDXW'(i);
                found = 1'b1;
            end
        end
        // A zero vector also reports last so it yields exactly one beat.
        last_o = ((rem_i & (rem_i - One)) == '0);
    end

endmodule

// File: rtl/setbit_enum.sv
// Expands a flag vector into an ascending stream of set-bit indices, one per handshake.
module setbit_enum
    import setbit_enum_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic          clk,
    input  logic          rst,
    setbit_enum_if.slave  bus_io
);

    localparam int unsigned IDXW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    state_e            state_q;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              valid_q;
    logic [IDXW-1:0]   idx_q;
    logic              last_q;
    logic              any_q;

    logic [IDXW-1:0]   penc_idx;
    logic              penc_last;
    logic              accept;
    logic              beat_done;

    assign accept    = bus_io.setbit_valid_i && (state_q == StIdle);
    assign beat_done = valid_q && bus_io.setbit_ready_i;

    // The encoder looks at the next remainder so each beat is registered.
    always_comb begin
        rem_d = rem_q;
        if (accept) begin
            rem_d = bus_io.setbit_vec_i;
        end else if (beat_done && !last_q) begin
            rem_d = rem_q & (rem_q - One);
        end
    end

    lsb_penc #(
        .WIDTH (WIDTH)
    ) u_penc (
        .rem_i  (rem_d),
        .idx_o  (penc_idx),
        .last_o (penc_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            any_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StBusy;
                        rem_q   <= rem_d;
                        valid_q <= 1'b1;
                        idx_q   <= penc_idx;
                        last_q  <= penc_last;
                        any_q   <= |bus_io.setbit_vec_i;
                    end
                end
                StBusy: begin
                    if (beat_done) begin
                        if (last_q) begin
                            state_q <= StIdle;
                            valid_q <= 1'b0;
                        end else begin
                            rem_q  <= rem_d;
                            idx_q  <= penc_idx;
                            last_q <= penc_last;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.setbit_ready_o = (state_q == StIdle);
    assign bus_io.setbit_valid_o = valid_q;
    assign bus_io.setbit_idx_o   = idx_q;
    assign bus_io.setbit_last_o  = last_q;
    assign bus_io.setbit_any_o   = any_q;

endmodule

// File: tb/tb_setbit_enum.sv
// Directed bench for setbit_enum: zero vector, extremes, full vector, stalls, busy input, reset.
module tb_setbit_enum;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    setbit_enum_if #(.WIDTH(64)) bus ();

    setbit_enum #(
        .WIDTH (64)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    // Advance one cycle; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one vector; returns in the cycle right after the accept edge.
    task automatic drive_vec(input logic [63:0] vec);
        int n;
        n = 0;
        while (!bus.setbit_ready_o && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (!bus.setbit_ready_o) begin
            errors++;
            $display("FAIL accept_timeout: ready_o=%0b after %0d cycles, required 1", bus.setbit_ready_o, n);
        end
        bus.setbit_valid_i = 1'b1;
        bus.setbit_vec_i   = vec;
        step();
        bus.setbit_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.setbit_valid_o !== 1'b0 || bus.setbit_ready_o !== 1'b1 || bus.setbit_idx_o !== 6'd0
            || bus.setbit_last_o !== 1'b0 || bus.setbit_any_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b idx=%0d last=%b any=%b, required 0 1 0 0 0",
                     bus.setbit_valid_o, bus.setbit_ready_o, bus.setbit_idx_o, bus.setbit_last_o,
                     bus.setbit_any_o);
        end
    endtask

    task automatic test_zero_vec();
        bus.setbit_ready_i = 1'b1;
        drive_vec(64'h0);
        checks++;
        if (bus.setbit_valid_o !== 1'b1 || bus.setbit_idx_o !== 6'd0 || bus.setbit_last_o !== 1'b1
            || bus.setbit_any_o !== 1'b0 || bus.setbit_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_beat: valid=%b idx=%0d last=%b any=%b ready=%b, required 1 0 1 0 0",
                     bus.setbit_valid_o, bus.setbit_idx_o, bus.setbit_last_o, bus.setbit_any_o,
                     bus.setbit_ready_o);
        end
        step();
        checks++;
        if (bus.setbit_valid_o !== 1'b0 || bus.setbit_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: valid=%b ready=%b, required 0 1",
                     bus.setbit_valid_o, bus.setbit_ready_o);
        end
    endtask

    task automatic test_extremes();
        bus.setbit_ready_i = 1'b1;
        drive_vec(64'h8000_0000_0000_0001);
        checks++;
        if (bus.setbit_valid_o !== 1'b1 || bus.setbit_idx_o !== 6'd0 || bus.setbit_last_o !== 1'b0
            || bus.setbit_any_o !== 1'b1) begin
            errors++;
            $display("FAIL extreme_beat0: valid=%b idx=%0d last=%b any=%b, required 1 0 0 1",
                     bus.setbit_valid_o, bus.setbit_idx_o, bus.setbit_last_o, bus.setbit_any_o);
        end
        step();
        checks++;
        if (bus.setbit_valid_o !== 1'b1 || bus.setbit_idx_o !== 6'd63 || bus.setbit_last_o !== 1'b1
            || bus.setbit_any_o !== 1'b1) begin
            errors++;
            $display("FAIL extreme_beat1: valid=%b idx=%0d last=%b any=%b, required 1 63 1 1",
                     bus.setbit_valid_o, bus.setbit_idx_o, bus.setbit_last_o, bus.setbit_any_o);
        end
        step();
        checks++;
        if (bus.setbit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL extreme_end: valid=%b, required 0", bus.setbit_valid_o);
        end
    endtask

    task automatic test_all_ones();
        bus.setbit_ready_i = 1'b1;
        drive_vec({64{1'b1}});
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (bus.setbit_valid_o !== 1'b1 || bus.setbit_idx_o !== 6'(i)
                || bus.setbit_last_o !== (i == 63) || bus.setbit_any_o !== 1'b1) begin
                errors++;
                $display("FAIL all_ones_beat%0d: valid=%b idx=%0d last=%b any=%b, required 1 %0d %b 1",
                         i, bus.setbit_valid_o, bus.setbit_idx_o, bus.setbit_last_o,
                         bus.setbit_any_o, i, (i == 63));
            end
            step();
        end
        checks++;
        if (bus.setbit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL all_ones_end: valid=%b, required 0", bus.setbit_valid_o);
        end
    endtask

    task automatic test_backpressure();
        int       k;
        int       cyc;
        bit       stalled;
        logic [5:0] p_idx;
        logic     p_last, p_any, p_valid;
        k       = 0;
        cyc     = 0;
        stalled = 1'b0;
        p_idx   = '0;
        p_last  = 1'b0;
        p_any   = 1'b0;
        p_valid = 1'b0;
        bus.setbit_ready_i = 1'b0;
        drive_vec(64'h0000_0000_0000_0F00);
        while (k < 4 && cyc < 200) begin
            if (stalled) begin
                checks++;
                if (bus.setbit_valid_o !== p_valid || bus.setbit_idx_o !== p_idx
                    || bus.setbit_last_o !== p_last || bus.setbit_any_o !== p_any) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%b idx=%0d last=%b any=%b, required %b %0d %b %b",
                             bus.setbit_valid_o, bus.setbit_idx_o, bus.setbit_last_o,
                             bus.setbit_any_o, p_valid, p_idx, p_last, p_any);
                end
            end
            checks++;
            if (bus.setbit_valid_o !== 1'b1 || bus.setbit_idx_o !== 6'(8 + k)
                || bus.setbit_last_o !== (k == 3) || bus.setbit_any_o !== 1'b1) begin
                errors++;
                $display("FAIL bp_beat%0d: valid=%b idx=%0d last=%b any=%b, required 1 %0d %b 1",
                         k, bus.setbit_valid_o, bus.setbit_idx_o, bus.setbit_last_o,
                         bus.setbit_any_o, 8 + k, (k == 3));
            end
            // Every beat is stalled at least once before random acceptance.
            bus.setbit_ready_i = stalled ? 1'($urandom_range(0, 1)) : 1'b0;
            stalled = !bus.setbit_ready_i;
            p_idx   = bus.setbit_idx_o;
            p_last  = bus.setbit_last_o;
            p_any   = bus.setbit_any_o;
            p_valid = bus.setbit_valid_o;
            if (bus.setbit_ready_i) k++;
            step();
            cyc++;
        end
        checks++;
        if (k != 4 || bus.setbit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: beats=%0d valid=%b, required 4 0", k, bus.setbit_valid_o);
        end
        bus.setbit_ready_i = 1'b1;
    endtask

    task automatic test_busy_ignore();
        bus.setbit_ready_i = 1'b0;
        drive_vec(64'h30);
        bus.setbit_valid_i = 1'b1;
        bus.setbit_vec_i   = 64'h1;
        checks++;
        if (bus.setbit_idx_o !== 6'd4 || bus.setbit_valid_o !== 1'b1 || bus.setbit_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_beat0: idx=%0d valid=%b ready=%b, required 4 1 0",
                     bus.setbit_idx_o, bus.setbit_valid_o, bus.setbit_ready_o);
        end
        step();
        bus.setbit_ready_i = 1'b1;
        checks++;
        if (bus.setbit_idx_o !== 6'd4 || bus.setbit_last_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_hold: idx=%0d last=%b, required 4 0",
                     bus.setbit_idx_o, bus.setbit_last_o);
        end
        step();
        checks++;
        if (bus.setbit_idx_o !== 6'd5 || bus.setbit_last_o !== 1'b1 || bus.setbit_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_beat1: idx=%0d last=%b valid=%b, required 5 1 1",
                     bus.setbit_idx_o, bus.setbit_last_o, bus.setbit_valid_o);
        end
        bus.setbit_valid_i = 1'b0;
        step();
        checks++;
        if (bus.setbit_valid_o !== 1'b0 || bus.setbit_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_idle: valid=%b ready=%b, required 0 1",
                     bus.setbit_valid_o, bus.setbit_ready_o);
        end
        step();
        checks++;
        if (bus.setbit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_not_captured: valid=%b, required 0", bus.setbit_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        bus.setbit_ready_i = 1'b1;
        drive_vec({64{1'b1}});
        step();
        checks++;
        if (bus.setbit_idx_o !== 6'd1 || bus.setbit_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_beat1: idx=%0d valid=%b, required 1 1",
                     bus.setbit_idx_o, bus.setbit_valid_o);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.setbit_valid_o !== 1'b0 || bus.setbit_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_flush: valid=%b ready=%b, required 0 1",
                     bus.setbit_valid_o, bus.setbit_ready_o);
        end
        step();
        checks++;
        if (bus.setbit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_partial: valid=%b, required 0", bus.setbit_valid_o);
        end
        drive_vec(64'h4);
        checks++;
        if (bus.setbit_valid_o !== 1'b1 || bus.setbit_idx_o !== 6'd2 || bus.setbit_last_o !== 1'b1
            || bus.setbit_any_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_next: valid=%b idx=%0d last=%b any=%b, required 1 2 1 1",
                     bus.setbit_valid_o, bus.setbit_idx_o, bus.setbit_last_o, bus.setbit_any_o);
        end
        step();
        checks++;
        if (bus.setbit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_end: valid=%b, required 0", bus.setbit_valid_o);
        end
    endtask

    initial begin
        bus.setbit_valid_i = 1'b0;
        bus.setbit_vec_i   = '0;
        bus.setbit_ready_i = 1'b1;
        test_reset();
        test_zero_vec();
        test_extremes();
        test_all_ones();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
